pc_ctrl: RTL and testbench

//   Program-counter controller; consumer of PCOp and of the JR/branch/jump targets

---
 rtl/pc_ctrl_if.sv | 26 ++
 rtl/pc_ctrl.sv | 91 +++++++++
 tb/tb_pc_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// Bundle between control decode and the program-counter controller.
// The decoder side (master) drives the next-PC controls and observes the fetch address and status.
interface pc_ctrl_if;
  logic        stall;
  logic [2:0]  PCOp;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] JR_control;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        trap;
  logic [31:0] epc;

  modport master (
    output stall, PCOp, branch_taken, imm16, imm26, JR_control,
    input  PC, PC_plus4, fetch_valid, flush, trap, epc
  );

  modport slave (
    input  stall, PCOp, branch_taken, imm16, imm26, JR_control,
    output PC, PC_plus4, fetch_valid, flush, trap, epc
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter controller: holds the architectural PC, selects the next PC,
// and traps misaligned jump-register targets to a fixed vector with a flush pulse.
module pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
  input  logic     clock,
  input  logic     reset,
  pc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        flush_q, flush_d;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= 32'h0000_0000;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      flush_q <= flush_d;
    end
  end

  // JR_control is only looked at under PCOp=100 so a floating bus never reaches the PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    flush_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.stall) begin
          case (bus.PCOp)
            3'b001: begin
              if (bus.branch_taken) begin
                pc_d    = pc_plus4 + br_off;
                flush_d = 1'b1;
              end else begin
                pc_d = pc_plus4;
              end
            end
            3'b010: begin
              pc_d    = {pc_plus4[31:28], bus.imm26, 2'b00};
              flush_d = 1'b1;
            end
            3'b100: begin
              if (bus.JR_control[1:0] != 2'b00) begin
                state_d = TRAP;
                pc_d    = TRAP_VECTOR;
                epc_d   = pc_q;
              end else begin
                pc_d    = bus.JR_control;
                flush_d = 1'b1;
              end
            end
            default: pc_d = pc_plus4;
          endcase
        end
      end
      TRAP: state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  assign bus.PC          = pc_q;
  assign bus.PC_plus4    = pc_plus4;
  assign bus.epc         = epc_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.trap        = (state_q == TRAP);
  assign bus.flush       = flush_q | (state_q == TRAP);

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: reset/boot, sequential fetch, branch, jump,
// jump-register with trap, stall, wrap-around and reset during a trap.
module tb_pc_ctrl;
  logic clock;
  logic reset;
  int   vecs;
  int   errs;

  pc_ctrl_if bus ();

  pc_ctrl #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0080)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall        = 1'b0;
    bus.PCOp         = 3'b000;
    bus.branch_taken = 1'b0;
    bus.imm16        = 16'h0000;
    bus.imm26        = 26'h0;
    bus.JR_control   = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) step();
    chk32("rst_pc", bus.PC, 32'h0);
    chk32("rst_pc4", bus.PC_plus4, 32'h4);
    chk1("rst_fv", bus.fetch_valid, 1'b0);
    chk1("rst_flush", bus.flush, 1'b0);
    chk1("rst_trap", bus.trap, 1'b0);
    chk32("rst_epc", bus.epc, 32'h0);
    reset = 1'b1;
    chk1("boot_fv", bus.fetch_valid, 1'b0);
    step();
    chk32("run_pc0", bus.PC, 32'h0);
    chk1("run_fv", bus.fetch_valid, 1'b1);
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      chk32("seq_pc", bus.PC, exp_pc);
      chk1("seq_flush", bus.flush, 1'b0);
    end
  endtask

  task automatic test_branch();
    bus.PCOp = 3'b001; bus.branch_taken = 1'b1; bus.imm16 = 16'hFFFE;
    step();
    chk32("br_taken_pc", bus.PC, 32'h0000_000C);
    chk1("br_taken_flush", bus.flush, 1'b1);
    idle_inputs();
    step();
    chk32("br_after_pc", bus.PC, 32'h0000_0010);
    chk1("br_after_flush", bus.flush, 1'b0);
    bus.PCOp = 3'b001; bus.branch_taken = 1'b0; bus.imm16 = 16'h0040;
    step();
    chk32("br_nt_pc", bus.PC, 32'h0000_0014);
    chk1("br_nt_flush", bus.flush, 1'b0);
    idle_inputs();
  endtask

  task automatic test_jump();
    bus.PCOp = 3'b100; bus.JR_control = 32'h1000_0040;
    step();
    chk32("jr_far_pc", bus.PC, 32'h1000_0040);
    chk1("jr_far_flush", bus.flush, 1'b1);
    bus.PCOp = 3'b010; bus.imm26 = 26'h0000100; bus.JR_control = 32'h0;
    step();
    chk32("j_pc", bus.PC, 32'h1000_0400);
    chk32("j_pc4", bus.PC_plus4, 32'h1000_0404);
    chk1("j_flush", bus.flush, 1'b1);
    idle_inputs();
  endtask

  task automatic test_jr_trap();
    bus.PCOp = 3'b100; bus.JR_control = 32'h0000_0200;
    step();
    chk32("jr_pc", bus.PC, 32'h0000_0200);
    chk1("jr_trap", bus.trap, 1'b0);
    bus.JR_control = 32'h0000_0202;
    step();
    chk32("trap_pc", bus.PC, 32'h0000_0080);
    chk1("trap_pulse", bus.trap, 1'b1);
    chk1("trap_flush", bus.flush, 1'b1);
    chk1("trap_fv", bus.fetch_valid, 1'b0);
    chk32("trap_epc", bus.epc, 32'h0000_0200);
    idle_inputs();
    step();
    chk32("post_trap_pc", bus.PC, 32'h0000_0080);
    chk1("post_trap_trap", bus.trap, 1'b0);
    chk1("post_trap_flush", bus.flush, 1'b0);
    chk1("post_trap_fv", bus.fetch_valid, 1'b1);
    step();
    chk32("post_trap_seq", bus.PC, 32'h0000_0084);
  endtask

  task automatic test_stall();
    bus.stall = 1'b1; bus.PCOp = 3'b100; bus.JR_control = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      step();
      chk32("stall_pc", bus.PC, 32'h0000_0084);
      chk1("stall_flush", bus.flush, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    chk32("unstall_pc", bus.PC, 32'h0000_0300);
    chk1("unstall_flush", bus.flush, 1'b1);
    bus.PCOp = 3'b011; bus.JR_control = 32'h0000_0002;
    step();
    chk32("op011_pc", bus.PC, 32'h0000_0304);
    chk1("op011_trap", bus.trap, 1'b0);
    chk1("op011_flush", bus.flush, 1'b0);
    bus.PCOp = 3'b111;
    step();
    chk32("op111_pc", bus.PC, 32'h0000_0308);
    idle_inputs();
  endtask

  task automatic test_wrap();
    bus.PCOp = 3'b100; bus.JR_control = 32'hFFFF_FFFC;
    step();
    chk32("wrap_pre_pc", bus.PC, 32'hFFFF_FFFC);
    chk32("wrap_pc4", bus.PC_plus4, 32'h0000_0000);
    idle_inputs();
    step();
    chk32("wrap_pc", bus.PC, 32'h0000_0000);
  endtask

  task automatic test_reset_in_trap();
    step();
    chk32("rit_seq_pc", bus.PC, 32'h0000_0004);
    bus.PCOp = 3'b100; bus.JR_control = 32'h0000_0101;
    step();
    chk1("rit_trap", bus.trap, 1'b1);
    chk32("rit_epc", bus.epc, 32'h0000_0004);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    chk32("rit_pc", bus.PC, 32'h0000_0000);
    chk1("rit_trap_drop", bus.trap, 1'b0);
    chk1("rit_flush_drop", bus.flush, 1'b0);
    chk32("rit_epc_clr", bus.epc, 32'h0);
    step();
    reset = 1'b1;
    chk1("rit_boot_fv", bus.fetch_valid, 1'b0);
    step();
    chk1("rit_run_fv", bus.fetch_valid, 1'b1);
    chk32("rit_run_pc", bus.PC, 32'h0);
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    reset = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_jr_trap();
    test_stall();
    test_wrap();
    test_reset_in_trap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
